// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration-time helpers for the parametrised FIFO family.
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  // Bits needed to address v entries.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic bit thresholds_ok(input int af, input int ae, input int depth);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1) && (ae < af);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read, contents not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, sticky error flags and an
// optional first-word-fall-through read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] out,
  output logic              empty,
  output logic              full,
  output logic              part_empty,
  output logic              part_full,
  output logic [ADDR_W:0]   fifo_counter,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_L    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   AE_L    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  if (!thresholds_ok(AF_LEVEL, AE_LEVEL, DEPTH) || clog2(DEPTH) != ADDR_W) begin : g_bad_cfg
    $error("sync_fifo_param: illegal AF_LEVEL/AE_LEVEL for this depth");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ok, wr_ok;

  fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    empty      = (cnt_q == '0);
    full       = (cnt_q == DEPTH_L);
    part_empty = (cnt_q <= AE_L);
    part_full  = (cnt_q >= AF_L);
    // A push into a full FIFO rides on a same-cycle pop freeing the slot.
    rd_ok      = rd_en & ~empty;
    wr_ok      = wr_en & (~full | rd_ok);

    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    out_d = rd_ok ? rd_data : out_q;
    // New error in the same cycle as clr_err keeps the flag set.
    ovf_d = (ovf_q & ~clr_err) | (wr_en & ~wr_ok);
    udf_d = (udf_q & ~clr_err) | (rd_en & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign out          = FWFT ? rd_data : out_q;
  assign fifo_counter = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed checks of the parametrised FIFO in registered and FWFT read modes.
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;

  logic [7:0] out0, out1;
  logic       empty0, full0, pe0, pf0, ovf0, udf0;
  logic       empty1, full1, pe1, pf1, ovf1, udf1;
  logic [3:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.FWFT(1'b0)) dut_reg (
    .clk(clk), .rst(rst), .in(din), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .out(out0), .empty(empty0), .full(full0), .part_empty(pe0), .part_full(pf0),
    .fifo_counter(cnt0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_param #(.FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .in(din), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .out(out1), .empty(empty1), .full(full1), .part_empty(pe1), .part_full(pf1),
    .fifo_counter(cnt1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus from a negedge; returns at the next negedge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic c, input logic rs);
    wr_en = w; din = d; rd_en = r; clr_err = c; rst = rs;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    chk("rst_cnt", cnt0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_pe", pe0, 1);
    chk("rst_pf", pf0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_udf", udf0, 0);
    chk("rst_out", out0, 0);

    // push 1,2,3 then pop three
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 8'(i), 0, 0, 0);
      chk("t1_push_cnt", cnt0, i);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("t1_pop_out", out0, i);
      chk("t1_pop_cnt", cnt0, 3 - i);
    end
    chk("t1_empty", empty0, 1);

    // fill 10..80 across pointer wrap
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(10 * i), 0, 0, 0);
      chk("t2_cnt", cnt0, i);
      chk("t2_pf", pf0, (i >= 6) ? 1 : 0);
      chk("t2_pe", pe0, (i <= 2) ? 1 : 0);
      chk("t2_full", full0, (i == 8) ? 1 : 0);
    end
    chk("t2_ovf_pre", ovf0, 0);
    cyc(1, 8'd90, 0, 0, 0);
    chk("t2_ovf", ovf0, 1);
    chk("t2_cnt9", cnt0, 8);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("t2_pop_out", out0, 10 * i);
    end
    chk("t2_empty", empty0, 1);
    cyc(0, 0, 0, 1, 0);
    chk("t2_clr_ovf", ovf0, 0);

    // simultaneous push+pop at full
    for (int i = 1; i <= 8; i++) cyc(1, 8'(20 + i), 0, 0, 0);
    chk("t3_full", full0, 1);
    cyc(1, 8'd99, 1, 0, 0);
    chk("t3_out", out0, 21);
    chk("t3_cnt", cnt0, 8);
    chk("t3_ovf", ovf0, 0);
    for (int i = 2; i <= 8; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("t3_drain", out0, 20 + i);
    end
    cyc(0, 0, 1, 0, 0);
    chk("t3_last", out0, 99);
    chk("t3_empty", empty0, 1);

    // simultaneous push+pop at empty
    cyc(1, 8'd5, 1, 0, 0);
    chk("t4_cnt", cnt0, 1);
    chk("t4_udf", udf0, 1);
    chk("t4_out_hold", out0, 99);
    cyc(0, 0, 1, 0, 0);
    chk("t4_out", out0, 5);
    chk("t4_cnt0", cnt0, 0);
    cyc(0, 0, 1, 1, 0);
    chk("t4_set_wins", udf0, 1);
    cyc(0, 0, 0, 1, 0);
    chk("t4_clr", udf0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("t4_udf_again", udf0, 1);

    // mid-operation reset
    for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("t6_cnt5", cnt0, 5);
    cyc(0, 0, 1, 0, 0);
    chk("t6_out_pre", out0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 8'hAA, 0, 0, 1);
    chk("t6_cnt", cnt0, 0);
    chk("t6_empty", empty0, 1);
    chk("t6_out", out0, 0);
    chk("t6_udf", udf0, 0);
    chk("t6_ovf", ovf0, 0);
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    chk("t6_fwft_head", out1, 'h11);
    cyc(0, 0, 1, 0, 0);
    chk("t6_pop1", out0, 'h11);
    cyc(0, 0, 1, 0, 0);
    chk("t6_pop2", out0, 'h22);

    // FWFT behaviour
    cyc(0, 0, 0, 0, 1);
    cyc(1, 8'd42, 0, 0, 0);
    chk("t5_out42", out1, 42);
    chk("t5_nempty", empty1, 0);
    cyc(0, 0, 1, 0, 0);
    chk("t5_empty", empty1, 1);
    cyc(1, 8'd7, 0, 0, 0);
    chk("t5_out7", out1, 7);
    cyc(1, 8'd8, 0, 0, 0);
    chk("t5_hold7", out1, 7);
    chk("t5_cnt2", cnt1, 2);
    cyc(0, 0, 1, 0, 0);
    chk("t5_out8", out1, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
